// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: IEEE 802.3 clause-22 register map, bit positions
// and the PHY manager state encoding.
package mdio_pkg;

  localparam logic [4:0] BMCR = 5'd0;
  localparam logic [4:0] BMSR = 5'd1;
  localparam logic [4:0] ANAR = 5'd4;

  localparam int BMCR_RST     = 15;
  localparam int BMSR_LINK    = 2;
  localparam int BMSR_AN_DONE = 5;

  localparam logic [15:0] BMCR_SOFT_RST   = 16'h8000;
  localparam logic [15:0] BMCR_AN_RESTART = 16'h1200;

  typedef enum logic [2:0] {
    ST_RST_WR   = 3'd0,
    ST_RST_POLL = 3'd1,
    ST_ANAR_WR  = 3'd2,
    ST_AN_WR    = 3'd3,
    ST_IDLE     = 3'd4,
    ST_POLL     = 3'd5,
    ST_HOST     = 3'd6,
    ST_GAP      = 3'd7
  } mdio_state_e;

  // States that own the MDIO engine and hold cyc_o high
  function automatic logic is_txn(input mdio_state_e s);
    return s inside {ST_RST_WR, ST_RST_POLL, ST_ANAR_WR, ST_AN_WR, ST_POLL, ST_HOST};
  endfunction

endpackage

// File: rtl/mdio_phy_mgr.sv
// PHY bring-up, periodic BMSR polling and host access arbitration onto a
// single MDIO transaction engine.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RST_WR    | write BMCR soft reset
// RST_POLL  | read BMCR until reset bit clears or read budget exhausted
// ANAR_WR   | write advertised abilities
// AN_WR     | enable and restart auto-negotiation
// IDLE      | arbitrate: host first, then pending poll
// POLL      | read BMSR, update link / AN status
// HOST      | run the captured host access
// GAP       | one cycle with cyc_o low, then gap_nxt_q
module mdio_phy_mgr
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter logic [15:0] ANAR_VAL     = 16'h01E1,
  parameter int          POLL_CYCLES  = 1_000_000,
  parameter int          RST_POLL_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cyc_o,
  output logic        we_o,
  output logic [4:0]  phy_adr_o,
  output logic [4:0]  reg_adr_o,
  output logic [15:0] tx_dat_o,
  input  logic        ack_i,
  input  logic [15:0] rx_dat_i,
  input  logic        host_cyc_i,
  input  logic        host_we_i,
  input  logic [4:0]  host_reg_adr_i,
  input  logic [15:0] host_dat_i,
  output logic        host_ack_o,
  output logic [15:0] host_dat_o,
  output logic        init_done_o,
  output logic        link_up_o,
  output logic        an_done_o,
  output logic        rst_timeout_o
);

  localparam int POLL_W = $clog2(POLL_CYCLES);
  localparam int RCNT_W = $clog2(RST_POLL_MAX + 1);
  localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RST_POLL_MAX - 1);

  mdio_state_e       state_q, state_d;
  mdio_state_e       gap_nxt_q, gap_nxt_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic              poll_pend_q, poll_pend_d;
  logic [RCNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [4:0]        reg_adr_q, reg_adr_d;
  logic [15:0]       tx_dat_q, tx_dat_d;
  logic              host_ack_q, host_ack_d;
  logic [15:0]       host_dat_q, host_dat_d;
  logic              init_done_q, init_done_d;
  logic              link_up_q, link_up_d;
  logic              an_done_q, an_done_d;
  logic              rst_timeout_q, rst_timeout_d;
  logic              ack_v;

  assign ack_v = cyc_q & ack_i;

  always_comb begin
    state_d       = state_q;
    gap_nxt_d     = gap_nxt_q;
    poll_cnt_d    = poll_cnt_q;
    poll_pend_d   = poll_pend_q;
    rst_cnt_d     = rst_cnt_q;
    we_d          = we_q;
    reg_adr_d     = reg_adr_q;
    tx_dat_d      = tx_dat_q;
    host_ack_d    = 1'b0;
    host_dat_d    = host_dat_q;
    init_done_d   = init_done_q;
    link_up_d     = link_up_q;
    an_done_d     = an_done_q;
    rst_timeout_d = rst_timeout_q;

    case (state_q)
      ST_RST_WR: begin
        if (ack_v) begin
          state_d   = ST_GAP;
          gap_nxt_d = ST_RST_POLL;
        end
      end
      ST_RST_POLL: begin
        if (ack_v) begin
          state_d = ST_GAP;
          if (!rx_dat_i[BMCR_RST]) begin
            gap_nxt_d = ST_ANAR_WR;
          end else if (rst_cnt_q == '0) begin
            rst_timeout_d = 1'b1;
            gap_nxt_d     = ST_ANAR_WR;
          end else begin
            rst_cnt_d = rst_cnt_q - 1'b1;
            gap_nxt_d = ST_RST_POLL;
          end
        end
      end
      ST_ANAR_WR: begin
        if (ack_v) begin
          state_d   = ST_GAP;
          gap_nxt_d = ST_AN_WR;
        end
      end
      ST_AN_WR: begin
        if (ack_v) begin
          state_d     = ST_GAP;
          gap_nxt_d   = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (host_cyc_i)       state_d = ST_HOST;
        else if (poll_pend_q) state_d = ST_POLL;
      end
      ST_POLL: begin
        if (ack_v) begin
          state_d     = ST_GAP;
          gap_nxt_d   = ST_IDLE;
          link_up_d   = rx_dat_i[BMSR_LINK];
          an_done_d   = rx_dat_i[BMSR_AN_DONE];
          poll_pend_d = 1'b0;
        end
      end
      ST_HOST: begin
        if (ack_v) begin
          state_d    = ST_GAP;
          gap_nxt_d  = ST_IDLE;
          host_ack_d = 1'b1;
          if (!we_q) host_dat_d = rx_dat_i;
        end
      end
      ST_GAP:  state_d = gap_nxt_q;
      default: state_d = ST_RST_WR;
    endcase

    // Timer terminal count after the POLL clear so a coincident expiry is not lost
    if (poll_cnt_q == '0) begin
      poll_cnt_d  = POLL_LOAD;
      poll_pend_d = 1'b1;
    end else begin
      poll_cnt_d = poll_cnt_q - 1'b1;
    end

    // Address/data are loaded only on the rising edge of cyc so they stay stable until ack
    cyc_d = is_txn(state_d);
    if (cyc_d && !cyc_q) begin
      case (state_d)
        ST_RST_WR:   begin we_d = 1'b1;      reg_adr_d = BMCR;           tx_dat_d = BMCR_SOFT_RST;   end
        ST_RST_POLL: begin we_d = 1'b0;      reg_adr_d = BMCR;           tx_dat_d = 16'h0000;        end
        ST_ANAR_WR:  begin we_d = 1'b1;      reg_adr_d = ANAR;           tx_dat_d = ANAR_VAL;        end
        ST_AN_WR:    begin we_d = 1'b1;      reg_adr_d = BMCR;           tx_dat_d = BMCR_AN_RESTART; end
        ST_POLL:     begin we_d = 1'b0;      reg_adr_d = BMSR;           tx_dat_d = 16'h0000;        end
        ST_HOST:     begin we_d = host_we_i; reg_adr_d = host_reg_adr_i; tx_dat_d = host_dat_i;      end
        default:     begin we_d = we_q;      reg_adr_d = reg_adr_q;      tx_dat_d = tx_dat_q;        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RST_WR;
      gap_nxt_q     <= ST_RST_WR;
      poll_cnt_q    <= POLL_LOAD;
      poll_pend_q   <= 1'b0;
      rst_cnt_q     <= RCNT_LOAD;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      reg_adr_q     <= 5'd0;
      tx_dat_q      <= 16'h0000;
      host_ack_q    <= 1'b0;
      host_dat_q    <= 16'h0000;
      init_done_q   <= 1'b0;
      link_up_q     <= 1'b0;
      an_done_q     <= 1'b0;
      rst_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_nxt_q     <= gap_nxt_d;
      poll_cnt_q    <= poll_cnt_d;
      poll_pend_q   <= poll_pend_d;
      rst_cnt_q     <= rst_cnt_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      reg_adr_q     <= reg_adr_d;
      tx_dat_q      <= tx_dat_d;
      host_ack_q    <= host_ack_d;
      host_dat_q    <= host_dat_d;
      init_done_q   <= init_done_d;
      link_up_q     <= link_up_d;
      an_done_q     <= an_done_d;
      rst_timeout_q <= rst_timeout_d;
    end
  end

  assign cyc_o         = cyc_q;
  assign we_o          = we_q;
  assign phy_adr_o     = PHY_ADDR;
  assign reg_adr_o     = reg_adr_q;
  assign tx_dat_o      = tx_dat_q;
  assign host_ack_o    = host_ack_q;
  assign host_dat_o    = host_dat_q;
  assign init_done_o   = init_done_q;
  assign link_up_o     = link_up_q;
  assign an_done_o     = an_done_q;
  assign rst_timeout_o = rst_timeout_q;

endmodule

// File: tb/tb_mdio_phy_mgr.sv
// Directed bench for mdio_phy_mgr: behavioural MDIO engine with a logged
// transaction history, checked against hand-computed expectations.
module tb_mdio_phy_mgr;

  localparam logic [4:0] PHY = 5'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_o, we_o;
  logic [4:0]  phy_adr_o, reg_adr_o;
  logic [15:0] tx_dat_o;
  logic        ack_i;
  logic [15:0] rx_dat_i;
  logic        host_cyc_i, host_we_i;
  logic [4:0]  host_reg_adr_i;
  logic [15:0] host_dat_i;
  logic        host_ack_o;
  logic [15:0] host_dat_o;
  logic        init_done_o, link_up_o, an_done_o, rst_timeout_o;

  always #5 clk = ~clk;

  mdio_phy_mgr #(
    .PHY_ADDR(PHY), .ANAR_VAL(16'h01E1), .POLL_CYCLES(200), .RST_POLL_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cyc_o(cyc_o), .we_o(we_o), .phy_adr_o(phy_adr_o), .reg_adr_o(reg_adr_o),
    .tx_dat_o(tx_dat_o), .ack_i(ack_i), .rx_dat_i(rx_dat_i),
    .host_cyc_i(host_cyc_i), .host_we_i(host_we_i), .host_reg_adr_i(host_reg_adr_i),
    .host_dat_i(host_dat_i), .host_ack_o(host_ack_o), .host_dat_o(host_dat_o),
    .init_done_o(init_done_o), .link_up_o(link_up_o), .an_done_o(an_done_o),
    .rst_timeout_o(rst_timeout_o)
  );

  int          n_chk = 0, n_err = 0;
  int          cyc_n = 0;
  int          lat = 64;
  logic [15:0] bmcr_rd = 16'h0000, bmsr_val = 16'h0000;

  logic        log_we[64];
  logic [4:0]  log_reg[64];
  logic [15:0] log_dat[64];
  int          log_cyc[64];
  logic        log_low[64];
  int          n_log = 0;
  int          stab_err = 0;
  int          n_hack = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_model(input logic [4:0] adr);
    case (adr)
      5'd0:    return bmcr_rd;
      5'd1:    return bmsr_val;
      5'd2:    return 16'h0022;
      default: return 16'h0000;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // MDIO engine model: acks after lat cycles of cyc_o, logs every transaction
  initial begin : engine
    int   wcnt;
    logic low_seen;
    wcnt = 0;
    low_seen = 1'b1;
    ack_i = 1'b0;
    rx_dat_i = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      ack_i = 1'b0;
      if (!cyc_o) low_seen = 1'b1;
      if (rst || !cyc_o) begin
        wcnt = 0;
      end else begin
        wcnt++;
        if (wcnt >= lat) begin
          ack_i = 1'b1;
          wcnt = 0;
          rx_dat_i = we_o ? 16'hDEAD : rd_model(reg_adr_o);
          if (n_log < 64) begin
            log_we[n_log]  = we_o;
            log_reg[n_log] = reg_adr_o;
            log_dat[n_log] = tx_dat_o;
            log_cyc[n_log] = cyc_n;
            log_low[n_log] = low_seen;
            n_log++;
          end
          low_seen = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic        pc;
    logic [21:0] pf;
    pc = 1'b0;
    pf = '0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_o && pc && ({we_o, reg_adr_o, tx_dat_o} != pf)) stab_err++;
      if (phy_adr_o != PHY) stab_err++;
      if (host_ack_o) n_hack++;
      pc = cyc_o;
      pf = {we_o, reg_adr_o, tx_dat_o};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_rst_outs(input string tag);
    chk({tag, "_cyc"},     cyc_o, 0);
    chk({tag, "_we"},      we_o, 0);
    chk({tag, "_reg"},     reg_adr_o, 0);
    chk({tag, "_tx"},      tx_dat_o, 0);
    chk({tag, "_hack"},    host_ack_o, 0);
    chk({tag, "_hdat"},    host_dat_o, 0);
    chk({tag, "_init"},    init_done_o, 0);
    chk({tag, "_link"},    link_up_o, 0);
    chk({tag, "_an"},      an_done_o, 0);
    chk({tag, "_timeout"}, rst_timeout_o, 0);
  endtask

  task automatic wait_init(input string tag, input int bound);
    int i = 0;
    while (!init_done_o && i < bound) begin
      tick(1);
      i++;
    end
    chk(tag, init_done_o, 1);
  endtask

  task automatic wait_log(input string tag, input int n, input int bound);
    int i = 0;
    while (n_log < n && i < bound) begin
      tick(1);
      i++;
    end
    chk(tag, n_log >= n, 1);
  endtask

  task automatic host_txn(input logic we, input logic [4:0] adr, input logic [15:0] dat,
                          input int bound, output int ack_at);
    int   i = 0;
    logic got = 1'b0;
    ack_at = -1;
    host_we_i = we;
    host_reg_adr_i = adr;
    host_dat_i = dat;
    host_cyc_i = 1'b1;
    while (!got && i < bound) begin
      tick(1);
      i++;
      if (host_ack_o) begin
        got = 1'b1;
        ack_at = cyc_n;
      end
    end
    host_cyc_i = 1'b0;
    chk("host_ack_seen", got, 1);
  endtask

  task automatic wait_cond_poll(input string tag, input int bound);
    int i = 0;
    while (!(cyc_o && reg_adr_o == 5'd1 && !we_o) && i < bound) begin
      tick(1);
      i++;
    end
    chk(tag, cyc_o && reg_adr_o == 5'd1, 1);
  endtask

  initial begin
    int p, k, ack_at, nreads, snap, i;
    rst = 1'b1;
    host_cyc_i = 1'b0;
    host_we_i = 1'b0;
    host_reg_adr_i = 5'd0;
    host_dat_i = 16'h0000;

    // Bring-up, slow engine, reset bit clears on first read
    tick(3);
    check_rst_outs("reset");
    n_log = 0;
    rst = 1'b0;
    tick(1);
    chk("first_cyc", cyc_o, 1);
    wait_init("t1_init", 2000);
    chk("t1_wr_rst",  {log_we[0], log_reg[0], log_dat[0]}, {1'b1, 5'd0, 16'h8000});
    chk("t1_rd_bmcr", {log_we[1], log_reg[1]}, {1'b0, 5'd0});
    chk("t1_wr_anar", {log_we[2], log_reg[2], log_dat[2]}, {1'b1, 5'd4, 16'h01E1});
    chk("t1_wr_an",   {log_we[3], log_reg[3], log_dat[3]}, {1'b1, 5'd0, 16'h1200});
    chk("t1_timeout", rst_timeout_o, 0);

    // Soft reset never clears
    rst = 1'b1;
    lat = 3;
    bmcr_rd = 16'h8000;
    tick(2);
    n_log = 0;
    rst = 1'b0;
    wait_init("t2_init", 500);
    nreads = 0;
    for (int j = 0; j < 7; j++) if (!log_we[j] && log_reg[j] == 5'd0) nreads++;
    chk("t2_rst_reads", nreads, 4);
    chk("t2_wr_anar", {log_we[5], log_reg[5], log_dat[5]}, {1'b1, 5'd4, 16'h01E1});
    chk("t2_wr_an",   {log_we[6], log_reg[6], log_dat[6]}, {1'b1, 5'd0, 16'h1200});
    chk("t2_timeout", rst_timeout_o, 1);

    // Periodic polling
    bmcr_rd = 16'h0000;
    bmsr_val = 16'h0024;
    n_log = 0;
    wait_log("t3_polls", 2, 600);
    chk("t3_poll_reg", {log_we[0], log_reg[0]}, {1'b0, 5'd1});
    chk("t3_period", log_cyc[1] - log_cyc[0], 200);
    tick(2);
    chk("t3_link1", link_up_o, 1);
    chk("t3_an1", an_done_o, 1);
    bmsr_val = 16'h0000;
    wait_log("t3_poll3", 3, 400);
    tick(2);
    chk("t3_link0", link_up_o, 0);
    chk("t3_an0", an_done_o, 0);

    // Host write colliding with poll timer expiry; timer edge derived from last poll ack
    p = log_cyc[2] - 3;
    while (cyc_n < p + 199) tick(1);
    k = n_log;
    bmsr_val = 16'h0004;
    host_txn(1'b1, 5'd4, 16'h01E1, 100, ack_at);
    chk("t5_host_first", {log_we[k], log_reg[k], log_dat[k]}, {1'b1, 5'd4, 16'h01E1});
    chk("t5_host_start", log_cyc[k], p + 202);
    chk("t5_ack_lat", ack_at - log_cyc[k], 1);
    chk("t5_wr_keeps_hdat", host_dat_o, 16'h0000);
    wait_log("t5_poll_seen", k + 2, 100);
    chk("t5_poll_next", {log_we[k+1], log_reg[k+1]}, {1'b0, 5'd1});
    chk("t5_gap_low", log_low[k+1], 1);
    tick(2);
    chk("t5_link", link_up_o, 1);
    chk("t5_an", an_done_o, 0);

    // Host read of PHY ID issued during bring-up
    rst = 1'b1;
    tick(2);
    lat = 20;
    n_log = 0;
    snap = n_hack;
    rst = 1'b0;
    host_txn(1'b0, 5'd2, 16'h0000, 1000, ack_at);
    chk("t4_init_last", {log_we[3], log_reg[3], log_dat[3]}, {1'b1, 5'd0, 16'h1200});
    chk("t4_host_after", {log_we[4], log_reg[4]}, {1'b0, 5'd2});
    chk("t4_hdat", host_dat_o, 16'h0022);
    tick(4);
    chk("t4_one_ack", n_hack - snap, 1);
    chk("t4_hdat_hold", host_dat_o, 16'h0022);

    // Reset asserted while a poll is in flight
    i = 0;
    while (!link_up_o && i < 600) begin
      tick(1);
      i++;
    end
    chk("t6_link_before", link_up_o, 1);
    wait_cond_poll("t6_poll_cyc", 400);
    rst = 1'b1;
    tick(1);
    check_rst_outs("midrst");
    tick(1);
    n_log = 0;
    lat = 3;
    rst = 1'b0;
    tick(1);
    chk("t6_first_cyc", cyc_o, 1);
    wait_log("t6_restart", 1, 50);
    chk("t6_wr_rst", {log_we[0], log_reg[0], log_dat[0]}, {1'b1, 5'd0, 16'h8000});

    chk("addr_data_stable", stab_err, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
